tcp_session_responder: RTL and testbench
========================================

TCP_SESSION_RESPONDER -- requirements
Module: tcp_session_responder

Interface
REQ-001 The block SHALL have parameter MAX_SESSIONS, default 16, giving the session table depth (power of 2, 2..64).
REQ-002 The block SHALL have parameter MAX_LISTEN, default 8, giving the listen port table depth.
REQ-003 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-004 `clk`  in  1  sole clock.
REQ-005 `rst_n`  in  1  asynchronous active-low reset.
REQ-006 `s_axis_listen_port`  axis_meta slave  16  listen request, data = port.
REQ-007 `m_axis_listen_port_status`  axis_meta master  8  listen result, data[0] = success.
REQ-008 `s_axis_open_connection`  axis_meta slave  48  open request, data = {port[47:32], ip[31:0]}.
REQ-009 `m_axis_open_status`  axis_meta master  24  open result, data = {7'b0, success[16], session[15:0]}.
REQ-010 `s_axis_close_connection`  axis_meta slave  16  close request, data = session.
REQ-011 `s_axis_conn_send`  axis_meta slave  21  bind request, data = {buffer_id[20:16], session[15:0]}.
REQ-012 `m_axis_conn_recv`  axis_meta master  22  bind result, data = {success[21], buffer_id[20:16], session[15:0]}.
REQ-013 `active_sessions`  out  8  count of open sessions.

Function
REQ-014 FSM states SHALL be IDLE, LISTEN_CHK, LISTEN_RSP, OPEN_CHK, OPEN_RSP, CLOSE, BIND_CHK, BIND_RSP.
REQ-015 In IDLE the block SHALL assert ready on exactly one valid slave, fixed priority close > listen > open > bind; all slave readys SHALL be 0 outside IDLE.
REQ-016 An accepted request SHALL be registered, and the FSM SHALL move to the matching CHK state, or to CLOSE for a close request.
REQ-017 LISTEN_CHK (1 cycle): success SHALL be 1 if the port is not already in the listen table and a free entry exists; on success the lowest free entry SHALL be written.
REQ-018 OPEN_CHK (1 cycle): success SHALL be 1 if no valid session has the same {ip,port} and a free slot exists; session = lowest free index, marked valid, buffer_id cleared to 0.
REQ-019 A failed open SHALL return session = 16'h0000 with success = 0, and the session table SHALL be unchanged.
REQ-020 BIND_CHK (1 cycle): success SHALL be 1 if session < MAX_SESSIONS and its slot is valid; on success the slot's buffer_id is stored; the response echoes buffer_id and session.
REQ-021 In each *_RSP state the block SHALL hold master valid=1 with stable data until ready, then return to IDLE on the next cycle.
REQ-022 Latency SHALL be: request handshake at cycle T gives response valid at T+2 (no backpressure).
REQ-023 CLOSE (1 cycle): if the session index is in range and valid, the slot SHALL be cleared; otherwise no effect. Close produces no response; return to IDLE.
REQ-024 Session indices ≥ MAX_SESSIONS SHALL be treated as invalid, with no out-of-range table access.
REQ-025 `active_sessions` SHALL increment on a successful open and decrement on an effective close, in the same cycle as the table update.
REQ-026 `active_sessions` SHALL never exceed MAX_SESSIONS nor underflow.
REQ-027 Only one request SHALL be in flight; simultaneous valids are served one per FSM pass in priority order; unserved requests stay pending (ready=0).

Reset
REQ-028 While rst_n=0, regardless of clock: FSM=IDLE, all tables invalid, all master valids=0, all slave readys=0, response data=0, active_sessions=0.
REQ-029 Reset asserted mid-transaction SHALL abort it; no partial table write or response SHALL survive.
REQ-030 Deassertion SHALL be synchronised internally; the first request SHALL be accepted no earlier than 2 cycles after rst_n rises.

Verification
REQ-031 Listen port 0x1F90 twice -> first status data[0]=1, second data[0]=0.
REQ-032 Open {0x1F90, 0x0A000001} -> status data=0x010000 (success, session 0); repeat same request -> data=0x000000; active_sessions=1.
REQ-033 Open 17 distinct peers, MAX_SESSIONS=16 -> sessions 0..15 succeed, 17th returns success=0; active_sessions=16.
REQ-034 Bind {5'd3, 16'd0} on open session -> conn_recv data=0x230000; bind session 16'd20 -> data=0x030014 (success=0).
REQ-035 Close session 0, then open a new peer -> returns session 0; close unopened session 5 -> active_sessions unchanged.
REQ-036 Close and listen valid in the same cycle, master ready held 0 for 10 cycles -> close served first, listen response valid held stable throughout; rst_n pulse mid-hold -> all valids 0 and tables empty.

Source files
------------

// File: rtl/tcp_session_responder.sv
// tcp_session_responder: listen/open/close/bind request FSM over axis_meta valid/ready/data channels with listen and session tables and an active_sessions count
module tcp_session_responder #(
  parameter int MAX_SESSIONS = 16,
  parameter int MAX_LISTEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axis_listen_port_valid,
  output logic        s_axis_listen_port_ready,
  input  logic [15:0] s_axis_listen_port_data,
  output logic        m_axis_listen_port_status_valid,
  input  logic        m_axis_listen_port_status_ready,
  output logic [7:0]  m_axis_listen_port_status_data,
  input  logic        s_axis_open_connection_valid,
  output logic        s_axis_open_connection_ready,
  input  logic [47:0] s_axis_open_connection_data,
  output logic        m_axis_open_status_valid,
  input  logic        m_axis_open_status_ready,
  output logic [23:0] m_axis_open_status_data,
  input  logic        s_axis_close_connection_valid,
  output logic        s_axis_close_connection_ready,
  input  logic [15:0] s_axis_close_connection_data,
  input  logic        s_axis_conn_send_valid,
  output logic        s_axis_conn_send_ready,
  input  logic [20:0] s_axis_conn_send_data,
  output logic        m_axis_conn_recv_valid,
  input  logic        m_axis_conn_recv_ready,
  output logic [21:0] m_axis_conn_recv_data,
  output logic [7:0]  active_sessions
);
  localparam int SW = $clog2(MAX_SESSIONS);
  localparam int LW = (MAX_LISTEN > 1) ? $clog2(MAX_LISTEN) : 1;
  typedef enum logic [2:0] {IDLE, LISTEN_CHK, LISTEN_RSP, OPEN_CHK, OPEN_RSP, CLOSE, BIND_CHK, BIND_RSP} state_t;
  state_t state, state_nxt;
  logic [1:0] rst_sync;
  logic run, accept;
  logic [47:0] req, req_in;
  logic [MAX_LISTEN-1:0] lst_vld;
  logic [15:0] lst_port [MAX_LISTEN];
  logic [MAX_SESSIONS-1:0] ses_vld;
  logic [47:0] ses_peer [MAX_SESSIONS];
  logic [4:0] ses_buf [MAX_SESSIONS];
  logic lst_hit, lst_free, ses_hit, ses_free;
  logic [LW-1:0] lst_idx;
  logic [SW-1:0] ses_idx, sidx;
  logic listen_ok_c, open_ok_c, sess_live;
  logic listen_ok, open_ok, bind_ok;
  logic [15:0] open_sess;
  assign run = rst_sync[1];
  assign sidx = req[SW-1:0];
  assign sess_live = (req[15:0] < 16'(MAX_SESSIONS)) && ses_vld[sidx];
  assign listen_ok_c = !lst_hit && lst_free;
  assign open_ok_c = !ses_hit && ses_free;
  assign accept = s_axis_close_connection_ready | s_axis_listen_port_ready | s_axis_open_connection_ready | s_axis_conn_send_ready;
  assign req_in = s_axis_close_connection_ready ? {32'd0, s_axis_close_connection_data} :
                  s_axis_listen_port_ready      ? {32'd0, s_axis_listen_port_data} :
                  s_axis_open_connection_ready  ? s_axis_open_connection_data :
                                                  {27'd0, s_axis_conn_send_data};
  always_comb begin
    lst_hit = 1'b0;
    lst_free = 1'b0;
    lst_idx = '0;
    for (int i = MAX_LISTEN - 1; i >= 0; i--) begin
      if (lst_vld[i] && lst_port[i] == req[15:0]) lst_hit = 1'b1;
      if (!lst_vld[i]) begin
        lst_free = 1'b1;
        lst_idx = LW'(i);
      end
    end
  end
  always_comb begin
    ses_hit = 1'b0;
    ses_free = 1'b0;
    ses_idx = '0;
    for (int i = MAX_SESSIONS - 1; i >= 0; i--) begin
      if (ses_vld[i] && ses_peer[i] == req) ses_hit = 1'b1;
      if (!ses_vld[i]) begin
        ses_free = 1'b1;
        ses_idx = SW'(i);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
      state <= IDLE;
      req <= '0;
      lst_vld <= '0;
      ses_vld <= '0;
      listen_ok <= 1'b0;
      open_ok <= 1'b0;
      bind_ok <= 1'b0;
      open_sess <= '0;
      active_sessions <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      state <= state_nxt;
      if (accept) req <= req_in;
      if (state == LISTEN_CHK) begin
        listen_ok <= listen_ok_c;
        if (listen_ok_c) lst_vld[lst_idx] <= 1'b1;
      end
      if (state == OPEN_CHK) begin
        open_ok <= open_ok_c;
        open_sess <= open_ok_c ? 16'(ses_idx) : 16'd0;
        if (open_ok_c) begin
          ses_vld[ses_idx] <= 1'b1;
          active_sessions <= active_sessions + 8'd1;
        end
      end
      if (state == CLOSE && sess_live) begin
        ses_vld[sidx] <= 1'b0;
        active_sessions <= active_sessions - 8'd1;
      end
      if (state == BIND_CHK) bind_ok <= sess_live;
    end
  end
  always_ff @(posedge clk) begin
    if (state == LISTEN_CHK && listen_ok_c) lst_port[lst_idx] <= req[15:0];
    if (state == OPEN_CHK && open_ok_c) begin
      ses_peer[ses_idx] <= req;
      ses_buf[ses_idx] <= 5'd0;
    end
    if (state == BIND_CHK && sess_live) ses_buf[sidx] <= req[20:16];
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = !run ? IDLE :
                              s_axis_close_connection_valid ? CLOSE :
                              s_axis_listen_port_valid ? LISTEN_CHK :
                              s_axis_open_connection_valid ? OPEN_CHK :
                              s_axis_conn_send_valid ? BIND_CHK : IDLE;
      LISTEN_CHK: state_nxt = LISTEN_RSP;
      LISTEN_RSP: state_nxt = m_axis_listen_port_status_ready ? IDLE : LISTEN_RSP;
      OPEN_CHK:   state_nxt = OPEN_RSP;
      OPEN_RSP:   state_nxt = m_axis_open_status_ready ? IDLE : OPEN_RSP;
      CLOSE:      state_nxt = IDLE;
      BIND_CHK:   state_nxt = BIND_RSP;
      BIND_RSP:   state_nxt = m_axis_conn_recv_ready ? IDLE : BIND_RSP;
      default:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    s_axis_close_connection_ready = (state == IDLE) && run && s_axis_close_connection_valid;
    s_axis_listen_port_ready = (state == IDLE) && run && s_axis_listen_port_valid && !s_axis_close_connection_valid;
    s_axis_open_connection_ready = (state == IDLE) && run && s_axis_open_connection_valid &&
                                   !s_axis_close_connection_valid && !s_axis_listen_port_valid;
    s_axis_conn_send_ready = (state == IDLE) && run && s_axis_conn_send_valid && !s_axis_close_connection_valid &&
                             !s_axis_listen_port_valid && !s_axis_open_connection_valid;
    m_axis_listen_port_status_valid = state == LISTEN_RSP;
    m_axis_open_status_valid = state == OPEN_RSP;
    m_axis_conn_recv_valid = state == BIND_RSP;
    m_axis_listen_port_status_data = {7'd0, listen_ok};
    m_axis_open_status_data = {7'd0, open_ok, open_sess};
    m_axis_conn_recv_data = {bind_ok, bind_ok ? ses_buf[sidx] : req[20:16], req[15:0]};
  end
endmodule

// File: tb/tb_tcp_session_responder.sv
// tb_tcp_session_responder: directed scoreboard bench for tcp_session_responder
module tb_tcp_session_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic lp_v, lp_r, ls_v, ls_r, oc_v, oc_r, os_v, os_r, cc_v, cc_r, cs_v, cs_r, cr_v, cr_r;
  logic [15:0] lp_d, cc_d;
  logic [7:0] ls_d, act;
  logic [47:0] oc_d;
  logic [23:0] os_d;
  logic [20:0] cs_d;
  logic [21:0] cr_d;
  logic [7:0] q_l[$];
  logic [23:0] q_o[$];
  logic [21:0] q_r[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  tcp_session_responder dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_listen_port_valid(lp_v), .s_axis_listen_port_ready(lp_r), .s_axis_listen_port_data(lp_d),
    .m_axis_listen_port_status_valid(ls_v), .m_axis_listen_port_status_ready(ls_r), .m_axis_listen_port_status_data(ls_d),
    .s_axis_open_connection_valid(oc_v), .s_axis_open_connection_ready(oc_r), .s_axis_open_connection_data(oc_d),
    .m_axis_open_status_valid(os_v), .m_axis_open_status_ready(os_r), .m_axis_open_status_data(os_d),
    .s_axis_close_connection_valid(cc_v), .s_axis_close_connection_ready(cc_r), .s_axis_close_connection_data(cc_d),
    .s_axis_conn_send_valid(cs_v), .s_axis_conn_send_ready(cs_r), .s_axis_conn_send_data(cs_d),
    .m_axis_conn_recv_valid(cr_v), .m_axis_conn_recv_ready(cr_r), .m_axis_conn_recv_data(cr_d),
    .active_sessions(act)
  );
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic unexpected(input string tag, input logic [47:0] obs);
    tests++;
    fails++;
    $error("FAIL %s observed=%h expected=no response", tag, obs);
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ls_v && ls_r) begin
          if (q_l.size() == 0) unexpected("listen_status", 48'(ls_d));
          else check("listen_status", 48'(ls_d), 48'(q_l.pop_front()));
        end
        if (os_v && os_r) begin
          if (q_o.size() == 0) unexpected("open_status", 48'(os_d));
          else check("open_status", 48'(os_d), 48'(q_o.pop_front()));
        end
        if (cr_v && cr_r) begin
          if (q_r.size() == 0) unexpected("conn_recv", 48'(cr_d));
          else check("conn_recv", 48'(cr_d), 48'(q_r.pop_front()));
        end
      end
    end
  endtask
  task automatic set_ch(input int ch, input logic v, input logic [47:0] d);
    case (ch)
      0: begin cc_v = v; cc_d = d[15:0]; end
      1: begin lp_v = v; lp_d = d[15:0]; end
      2: begin oc_v = v; oc_d = d; end
      default: begin cs_v = v; cs_d = d[20:0]; end
    endcase
  endtask
  function automatic logic rdy(input int ch);
    return ch == 0 ? cc_r : ch == 1 ? lp_r : ch == 2 ? oc_r : cs_r;
  endfunction
  task automatic req(input int ch, input logic [47:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    set_ch(ch, 1'b1, d);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy(ch)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    set_ch(ch, 1'b0, d);
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL req_timeout ch=%0d observed=0 expected=1", ch);
    end
  endtask
  task automatic drain();
    for (int n = 0; n < 300 && (q_l.size() + q_o.size() + q_r.size()) != 0; n++) @(negedge clk);
    if ((q_l.size() + q_o.size() + q_r.size()) != 0) begin
      tests++;
      fails++;
      $error("FAIL drain_timeout observed=%0d expected=0", q_l.size() + q_o.size() + q_r.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    fork monitor(); join_none
    rst_n = 1'b0;
    {lp_v, oc_v, cc_v, cs_v} = '0;
    lp_d = '0; oc_d = '0; cc_d = '0; cs_d = '0;
    {ls_r, os_r, cr_r} = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    cc_v = 1'b1;
    lp_v = 1'b1;
    lp_d = 16'h1F90;
    @(negedge clk);
    check("rst_close_ready", 48'(cc_r), 48'd0);
    check("rst_listen_ready", 48'(lp_r), 48'd0);
    check("rst_valids", 48'({ls_v, os_v, cr_v}), 48'd0);
    check("rst_active", 48'(act), 48'd0);
    check("rst_data", 48'({ls_d, os_d, cr_d}), 48'd0);
    cc_v = 1'b0;
    rst_n = 1'b1;
    q_l.push_back(8'h01);
    @(negedge clk);
    check("sync_ready_early", 48'(lp_r), 48'd0);
    for (int n = 0; n < 20 && !lp_r; n++) @(negedge clk);
    check("sync_ready_late", 48'(lp_r), 48'd1);
    @(posedge clk); #1;
    lp_v = 1'b0;
    q_l.push_back(8'h00);
    req(1, 48'h1F90);
    drain();
    q_o.push_back(24'h010000);
    req(2, {16'h1F90, 32'h0A000001});
    check("lat_t1_valid", 48'(os_v), 48'd0);
    @(posedge clk); #1;
    check("lat_t2_valid", 48'(os_v), 48'd1);
    q_o.push_back(24'h000000);
    req(2, {16'h1F90, 32'h0A000001});
    drain();
    check("active_one", 48'(act), 48'd1);
    for (int i = 1; i < 16; i++) begin
      q_o.push_back(24'h010000 | 24'(i));
      req(2, {16'h1F90, 32'h0A000001 + 32'(i)});
    end
    q_o.push_back(24'h000000);
    req(2, {16'h1F90, 32'h0A0000FF});
    drain();
    check("active_full", 48'(act), 48'd16);
    q_r.push_back(22'h230000);
    req(3, 48'({5'd3, 16'd0}));
    q_r.push_back(22'h030014);
    req(3, 48'({5'd3, 16'd20}));
    q_r.push_back(22'h010010);
    req(3, 48'({5'd1, 16'd16}));
    drain();
    req(0, 48'd0);
    drain();
    check("active_close0", 48'(act), 48'd15);
    q_o.push_back(24'h010000);
    req(2, {16'h1F90, 32'h0A000100});
    drain();
    check("active_reopen", 48'(act), 48'd16);
    req(0, 48'd5);
    drain();
    check("active_close5", 48'(act), 48'd15);
    req(0, 48'd5);
    req(0, 48'd100);
    drain();
    check("active_noop_close", 48'(act), 48'd15);
    q_r.push_back(22'h020005);
    req(3, 48'({5'd2, 16'd5}));
    drain();
    ls_r = 1'b0;
    cc_v = 1'b1;
    cc_d = 16'd1;
    lp_v = 1'b1;
    lp_d = 16'h0050;
    q_l.push_back(8'h01);
    @(negedge clk);
    check("prio_close_ready", 48'(cc_r), 48'd1);
    check("prio_listen_ready", 48'(lp_r), 48'd0);
    @(posedge clk); #1;
    cc_v = 1'b0;
    for (int n = 0; n < 20 && !lp_r; n++) @(negedge clk);
    check("prio_listen_accept", 48'(lp_r), 48'd1);
    @(posedge clk); #1;
    lp_v = 1'b0;
    for (int n = 0; n < 20 && !ls_v; n++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 48'(ls_v), 48'd1);
      check("hold_data", 48'(ls_d), 48'h01);
    end
    check("active_prio_close", 48'(act), 48'd14);
    @(posedge clk); #1;
    rst_n = 1'b0;
    lp_v = 1'b1;
    #1;
    check("midrst_valids", 48'({ls_v, os_v, cr_v}), 48'd0);
    check("midrst_ready", 48'(lp_r), 48'd0);
    check("midrst_active", 48'(act), 48'd0);
    check("midrst_data", 48'({ls_d, os_d, cr_d}), 48'd0);
    q_l.delete();
    lp_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ls_r = 1'b1;
    q_o.push_back(24'h010000);
    req(2, {16'h1F90, 32'h0A000001});
    q_r.push_back(22'h000001);
    req(3, 48'({5'd0, 16'd1}));
    q_l.push_back(8'h01);
    req(1, 48'h1F90);
    for (int i = 1; i < 8; i++) begin
      q_l.push_back(8'h01);
      req(1, 48'(16'h2000 + 16'(i)));
    end
    q_l.push_back(8'h00);
    req(1, 48'h3000);
    drain();
    check("active_after_rst", 48'(act), 48'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
